// File: rtl/mwrite_sb.sv
// mwrite_sb: byte-merging store buffer feeding MMU writes in FIFO order.
// Ports: CLK/RST (sync, active-high), STALL; MEMR_* load, ALU and store
//   inputs; DATA_W* write request to MMU with DATA_WREADY handshake;
//   SB_STALL_REQ/SB_EMPTY/SB_COUNT status; MEMW_REG_W_* write-back register.
// Option: define MWRITE_SB_BYPASS_EN to pass a store straight through to
//   the MMU when the buffer is empty and DATA_WREADY is high.
module mwrite_sb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              MEMR_MEM_R_VALID,
  input  logic [4:0]        MEMR_MEM_R_RD,
  input  logic [DATA_W-1:0] MEMR_MEM_R_DATA,
  input  logic [4:0]        MEMR_REG_W_RD,
  input  logic [DATA_W-1:0] MEMR_REG_W_DATA,
  input  logic              MEMR_MEM_W_VALID,
  input  logic [DATA_W-1:0] MEMR_MEM_W_ADDR,
  input  logic [7:0]        MEMR_MEM_W_STRB,
  input  logic [DATA_W-1:0] MEMR_MEM_W_DATA,
  output logic              DATA_WREN,
  output logic [DATA_W-1:0] DATA_WADDR,
  output logic [DATA_W-1:0] DATA_WDATA,
  input  logic              DATA_WREADY,
  output logic              SB_STALL_REQ,
  output logic              SB_EMPTY,
  output logic [CW-1:0]     SB_COUNT,
  output logic [4:0]        MEMW_REG_W_RD,
  output logic [DATA_W-1:0] MEMW_REG_W_DATA
);

  localparam int NB = DATA_W / 8;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [DATA_W-1:0] merged;
  logic              full, empty, accept, push, pop, byp;

  // Lanes without a strobe keep the read-before-write data; an all-zero
  // strobe means a plain full-word store.
  always_comb begin
    merged = MEMR_MEM_R_DATA;
    for (int i = 0; i < NB; i++) begin
      if (MEMR_MEM_W_STRB[i])
        merged[8*i +: 8] = MEMR_MEM_W_DATA[8*i +: 8];
    end
    if (MEMR_MEM_W_STRB == 8'd0)
      merged = MEMR_MEM_W_DATA;
  end

  // full looks only at the registered count, so a pop this cycle never
  // makes room for a push in the same cycle.
  assign full   = (cnt_q == FULL_CNT);
  assign empty  = (cnt_q == '0);
  assign accept = MEMR_MEM_W_VALID && !STALL && !full;
  assign pop    = !empty && DATA_WREADY;

`ifdef MWRITE_SB_BYPASS_EN
  assign byp = accept && empty && DATA_WREADY;
`else
  assign byp = 1'b0;
`endif

  assign push = accept && !byp;

  assign SB_STALL_REQ = MEMR_MEM_W_VALID && full;
  assign SB_EMPTY     = empty;
  assign SB_COUNT     = cnt_q;
  assign DATA_WREN    = !empty || byp;

  // Idle write port is driven to zero rather than showing a stale slot.
  always_comb begin
    DATA_WADDR = '0;
    DATA_WDATA = '0;
    if (byp) begin
      DATA_WADDR = MEMR_MEM_W_ADDR;
      DATA_WDATA = merged;
    end else if (!empty) begin
      DATA_WADDR = addr_q[head_q];
      DATA_WDATA = data_q[head_q];
    end
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push) begin
      addr_d[tail_q] = MEMR_MEM_W_ADDR;
      data_d[tail_q] = merged;
      tail_d         = tail_q + PW'(1);
    end
    if (pop)
      head_d = head_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (!STALL) begin
      if (MEMR_MEM_R_VALID) begin
        wb_rd_d   = MEMR_MEM_R_RD;
        wb_data_d = MEMR_MEM_R_DATA;
      end else begin
        wb_rd_d   = MEMR_REG_W_RD;
        wb_data_d = MEMR_REG_W_DATA;
      end
    end
  end

  assign MEMW_REG_W_RD   = wb_rd_q;
  assign MEMW_REG_W_DATA = wb_data_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Payload storage needs no reset: slots are only read when counted.
  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_mwrite_sb.sv
// tb_mwrite_sb: directed and random checks of mwrite_sb against a
// queue-based reference model (DATA_W=32, DEPTH=4, no bypass).
module tb_mwrite_sb;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST, STALL;
  logic          MEMR_MEM_R_VALID;
  logic [4:0]    MEMR_MEM_R_RD;
  logic [DW-1:0] MEMR_MEM_R_DATA;
  logic [4:0]    MEMR_REG_W_RD;
  logic [DW-1:0] MEMR_REG_W_DATA;
  logic          MEMR_MEM_W_VALID;
  logic [DW-1:0] MEMR_MEM_W_ADDR;
  logic [7:0]    MEMR_MEM_W_STRB;
  logic [DW-1:0] MEMR_MEM_W_DATA;
  logic          DATA_WREN;
  logic [DW-1:0] DATA_WADDR, DATA_WDATA;
  logic          DATA_WREADY;
  logic          SB_STALL_REQ, SB_EMPTY;
  logic [2:0]    SB_COUNT;
  logic [4:0]    MEMW_REG_W_RD;
  logic [DW-1:0] MEMW_REG_W_DATA;

  mwrite_sb #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL),
    .MEMR_MEM_R_VALID(MEMR_MEM_R_VALID),
    .MEMR_MEM_R_RD(MEMR_MEM_R_RD),
    .MEMR_MEM_R_DATA(MEMR_MEM_R_DATA),
    .MEMR_REG_W_RD(MEMR_REG_W_RD),
    .MEMR_REG_W_DATA(MEMR_REG_W_DATA),
    .MEMR_MEM_W_VALID(MEMR_MEM_W_VALID),
    .MEMR_MEM_W_ADDR(MEMR_MEM_W_ADDR),
    .MEMR_MEM_W_STRB(MEMR_MEM_W_STRB),
    .MEMR_MEM_W_DATA(MEMR_MEM_W_DATA),
    .DATA_WREN(DATA_WREN),
    .DATA_WADDR(DATA_WADDR),
    .DATA_WDATA(DATA_WDATA),
    .DATA_WREADY(DATA_WREADY),
    .SB_STALL_REQ(SB_STALL_REQ),
    .SB_EMPTY(SB_EMPTY),
    .SB_COUNT(SB_COUNT),
    .MEMW_REG_W_RD(MEMW_REG_W_RD),
    .MEMW_REG_W_DATA(MEMW_REG_W_DATA)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qd[$];
  logic [4:0]    m_rd;
  logic [DW-1:0] m_data;

  function automatic logic [DW-1:0] merge_ref(
    input logic [DW-1:0] w, input logic [DW-1:0] r,
    input logic [7:0] s);
    logic [DW-1:0] o;
    if (s == 8'd0) return w;
    for (int i = 0; i < DW / 8; i++)
      o[8*i +: 8] = s[i] ? w[8*i +: 8] : r[8*i +: 8];
    return o;
  endfunction

  // Model of what the edge about to happen does, from current inputs.
  task automatic model_edge();
    bit was_full;
    if (RST) begin
      qa.delete(); qd.delete();
      m_rd = '0; m_data = '0;
      return;
    end
    was_full = (qa.size() == DEPTH);
    if (DATA_WREADY && qa.size() > 0) begin
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
    if (MEMR_MEM_W_VALID && !STALL && !was_full) begin
      qa.push_back(MEMR_MEM_W_ADDR);
      qd.push_back(merge_ref(MEMR_MEM_W_DATA, MEMR_MEM_R_DATA,
                             MEMR_MEM_W_STRB));
    end
    if (!STALL) begin
      m_rd   = MEMR_MEM_R_VALID ? MEMR_MEM_R_RD : MEMR_REG_W_RD;
      m_data = MEMR_MEM_R_VALID ? MEMR_MEM_R_DATA : MEMR_REG_W_DATA;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    STALL = 0; MEMR_MEM_R_VALID = 0; MEMR_MEM_R_RD = '0;
    MEMR_MEM_R_DATA = '0; MEMR_REG_W_RD = '0; MEMR_REG_W_DATA = '0;
    MEMR_MEM_W_VALID = 0; MEMR_MEM_W_ADDR = '0;
    MEMR_MEM_W_STRB = '0; MEMR_MEM_W_DATA = '0; DATA_WREADY = 0;
  endtask

  task automatic store(input logic [DW-1:0] a, input logic [DW-1:0] d,
                       input logic [7:0] s, input logic [DW-1:0] r);
    MEMR_MEM_W_VALID = 1; MEMR_MEM_W_ADDR = a;
    MEMR_MEM_W_DATA = d; MEMR_MEM_W_STRB = s; MEMR_MEM_R_DATA = r;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    tick(); tick();
    RST = 0;
    #2;
    n_cmp++;
    if (SB_EMPTY !== 1'b1 || DATA_WREN !== 1'b0 || SB_COUNT !== 3'd0 ||
        SB_STALL_REQ !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: empty=%b wren=%b cnt=%0d sreq=%b req 1 0 0 0",
               SB_EMPTY, DATA_WREN, SB_COUNT, SB_STALL_REQ);
    end
    n_cmp++;
    if (MEMW_REG_W_RD !== 5'd0 || MEMW_REG_W_DATA !== '0 ||
        DATA_WADDR !== '0 || DATA_WDATA !== '0) begin
      n_err++;
      $display("FAIL reset_outs: rd=%0d d=%h wa=%h wd=%h req all 0",
               MEMW_REG_W_RD, MEMW_REG_W_DATA, DATA_WADDR, DATA_WDATA);
    end
  endtask

  task automatic test_merge();
    logic [DW-1:0] exp_d;
    idle_inputs();
    DATA_WREADY = 1;
    store(32'h40, 32'hAABBCCDD, 8'b0110, 32'h11223344);
    tick();
    idle_inputs();
    DATA_WREADY = 1;
    #2;
    n_cmp++;
    if (DATA_WREN !== 1'b1 || DATA_WDATA !== 32'h11BBCC44 ||
        DATA_WADDR !== 32'h40) begin
      n_err++;
      $display("FAIL merge_0110: wren=%b wa=%h wd=%h req 1 40 11bbcc44",
               DATA_WREN, DATA_WADDR, DATA_WDATA);
    end
    store(32'h44, 32'hDEADBEEF, 8'b0000, 32'h01020304);
    tick();
    idle_inputs();
    DATA_WREADY = 1;
    #2;
    n_cmp++;
    if (DATA_WDATA !== 32'hDEADBEEF || SB_COUNT !== 3'd1) begin
      n_err++;
      $display("FAIL merge_zero_strb: wd=%h cnt=%0d req deadbeef 1",
               DATA_WDATA, SB_COUNT);
    end
    store(32'h48, 32'h55667788, 8'b1001, 32'hCAFEF00D);
    tick();
    idle_inputs();
    DATA_WREADY = 1;
    #2;
    exp_d = 32'h55FEF088;
    n_cmp++;
    if (DATA_WDATA !== exp_d) begin
      n_err++;
      $display("FAIL merge_1001: wd=%h req %h", DATA_WDATA, exp_d);
    end
    tick();
    #2;
    n_cmp++;
    if (SB_EMPTY !== 1'b1) begin
      n_err++;
      $display("FAIL merge_drain: empty=%b req 1", SB_EMPTY);
    end
  endtask

  task automatic test_full();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      store(32'h100 + 4 * i, 32'hA0 + i, 8'h0, '0);
      #2;
      if (i == 4) begin
        n_cmp++;
        if (SB_STALL_REQ !== 1'b1 || SB_COUNT !== 3'd4) begin
          n_err++;
          $display("FAIL full_stall_req: sreq=%b cnt=%0d req 1 4",
                   SB_STALL_REQ, SB_COUNT);
        end
      end
      if (i > 0) begin
        n_cmp++;
        if (DATA_WADDR !== 32'h100) begin
          n_err++;
          $display("FAIL full_head: wa=%h req 100", DATA_WADDR);
        end
      end
      tick();
    end
    store(32'h200, 32'h1, 8'h0, '0);
    DATA_WREADY = 1;
    #2;
    n_cmp++;
    if (SB_STALL_REQ !== 1'b1) begin
      n_err++;
      $display("FAIL full_pop_sreq: sreq=%b req 1", SB_STALL_REQ);
    end
    tick();
    MEMR_MEM_W_VALID = 0;
    #2;
    n_cmp++;
    if (SB_COUNT !== 3'd3 || DATA_WADDR !== 32'h104) begin
      n_err++;
      $display("FAIL full_pop_nopush: cnt=%0d wa=%h req 3 104",
               SB_COUNT, DATA_WADDR);
    end
    for (int i = 0; i < 3; i++) begin
      #0;
      n_cmp++;
      if (DATA_WREN !== 1'b1 || DATA_WADDR !== 32'h104 + 4 * i ||
          DATA_WDATA !== 32'hA1 + i) begin
        n_err++;
        $display("FAIL full_drain%0d: wren=%b wa=%h wd=%h", i,
                 DATA_WREN, DATA_WADDR, DATA_WDATA);
      end
      tick();
      #2;
    end
    n_cmp++;
    if (SB_EMPTY !== 1'b1 || qa.size() != 0) begin
      n_err++;
      $display("FAIL full_end_empty: empty=%b req 1", SB_EMPTY);
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int seen = 0;
    int cyc = 0;
    logic [DW-1:0] exp_a;
    idle_inputs();
    while ((sent < 10 || qa.size() > 0) && cyc < 200) begin
      DATA_WREADY = (cyc % 2 == 0);
      if (sent < 10) begin
        store(32'h300 + 16 * sent, $urandom, 4'($urandom), $urandom);
      end else begin
        MEMR_MEM_W_VALID = 0;
      end
      #2;
      n_cmp++;
      if (SB_COUNT !== 3'(qa.size()) ||
          SB_STALL_REQ !== (MEMR_MEM_W_VALID && qa.size() == DEPTH)) begin
        n_err++;
        $display("FAIL wrap_cnt: cnt=%0d sreq=%b req %0d", SB_COUNT,
                 SB_STALL_REQ, qa.size());
      end
      if (DATA_WREN && DATA_WREADY) begin
        exp_a = 32'h300 + 16 * seen;
        n_cmp++;
        if (DATA_WADDR !== exp_a || DATA_WDATA !== qd[0]) begin
          n_err++;
          $display("FAIL wrap_order: wa=%h wd=%h req %h %h", DATA_WADDR,
                   DATA_WDATA, exp_a, qd[0]);
        end
        seen++;
      end
      if (MEMR_MEM_W_VALID && !SB_STALL_REQ) sent++;
      tick();
      cyc++;
    end
    n_cmp++;
    if (seen != 10) begin
      n_err++;
      $display("FAIL wrap_total: got %0d writes req 10", seen);
    end
  endtask

  task automatic test_writeback();
    idle_inputs();
    MEMR_REG_W_RD = 5'd9; MEMR_REG_W_DATA = 32'h99;
    tick();
    STALL = 1;
    MEMR_MEM_R_VALID = 1; MEMR_MEM_R_RD = 5'd5;
    MEMR_MEM_R_DATA = 32'h12345678;
    tick();
    #2;
    n_cmp++;
    if (MEMW_REG_W_RD !== 5'd9 || MEMW_REG_W_DATA !== 32'h99) begin
      n_err++;
      $display("FAIL wb_stall_hold: rd=%0d d=%h req 9 99",
               MEMW_REG_W_RD, MEMW_REG_W_DATA);
    end
    STALL = 0;
    tick();
    #2;
    n_cmp++;
    if (MEMW_REG_W_RD !== 5'd5 || MEMW_REG_W_DATA !== 32'h12345678) begin
      n_err++;
      $display("FAIL wb_load: rd=%0d d=%h req 5 12345678",
               MEMW_REG_W_RD, MEMW_REG_W_DATA);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      STALL = ($urandom % 4 == 0);
      MEMR_MEM_R_VALID = $urandom % 2;
      MEMR_MEM_R_RD = 5'($urandom);
      MEMR_MEM_R_DATA = $urandom;
      MEMR_REG_W_RD = 5'($urandom);
      MEMR_REG_W_DATA = $urandom;
      MEMR_MEM_W_VALID = $urandom % 2;
      MEMR_MEM_W_ADDR = $urandom;
      MEMR_MEM_W_STRB = 8'($urandom % 16);
      MEMR_MEM_W_DATA = $urandom;
      DATA_WREADY = ($urandom % 3 == 0);
      #2;
      n_cmp++;
      if (SB_COUNT !== 3'(qa.size()) || SB_EMPTY !== (qa.size() == 0) ||
          DATA_WREN !== (qa.size() != 0) ||
          SB_STALL_REQ !== (MEMR_MEM_W_VALID && qa.size() == DEPTH)) begin
        n_err++;
        $display("FAIL rand_status c%0d: cnt=%0d e=%b wren=%b sreq=%b req cnt %0d",
                 c, SB_COUNT, SB_EMPTY, DATA_WREN, SB_STALL_REQ, qa.size());
      end
      if (qa.size() > 0) begin
        n_cmp++;
        if (DATA_WADDR !== qa[0] || DATA_WDATA !== qd[0]) begin
          n_err++;
          $display("FAIL rand_head c%0d: wa=%h wd=%h req %h %h", c,
                   DATA_WADDR, DATA_WDATA, qa[0], qd[0]);
        end
      end
      n_cmp++;
      if (MEMW_REG_W_RD !== m_rd || MEMW_REG_W_DATA !== m_data) begin
        n_err++;
        $display("FAIL rand_wb c%0d: rd=%0d d=%h req %0d %h", c,
                 MEMW_REG_W_RD, MEMW_REG_W_DATA, m_rd, m_data);
      end
      tick();
    end
  endtask

  task automatic test_reset_pending();
    idle_inputs();
    RST = 1; tick(); RST = 0;
    MEMR_REG_W_RD = 5'd3; MEMR_REG_W_DATA = 32'h33;
    for (int i = 0; i < 3; i++) begin
      store(32'h500 + 4 * i, 32'h7 + i, 8'h0, '0);
      tick();
    end
    idle_inputs();
    #2;
    n_cmp++;
    if (SB_COUNT !== 3'd3 || MEMW_REG_W_RD !== 5'd3) begin
      n_err++;
      $display("FAIL rstp_pre: cnt=%0d rd=%0d req 3 3", SB_COUNT,
               MEMW_REG_W_RD);
    end
    RST = 1; STALL = 1;
    store(32'h600, 32'h1, 8'h0, '0);
    tick();
    RST = 0; idle_inputs();
    #2;
    n_cmp++;
    if (SB_EMPTY !== 1'b1 || DATA_WREN !== 1'b0 || SB_COUNT !== 3'd0 ||
        DATA_WADDR !== '0 || DATA_WDATA !== '0 ||
        MEMW_REG_W_RD !== 5'd0 || MEMW_REG_W_DATA !== '0) begin
      n_err++;
      $display("FAIL rstp_clear: e=%b wren=%b cnt=%0d wa=%h wd=%h rd=%0d d=%h req 1 0 0 0 0 0 0",
               SB_EMPTY, DATA_WREN, SB_COUNT, DATA_WADDR, DATA_WDATA,
               MEMW_REG_W_RD, MEMW_REG_W_DATA);
    end
  endtask

  initial begin
    RST = 1;
    m_rd = '0; m_data = '0;
    @(posedge CLK);
    #1;
    test_reset();
    test_merge();
    test_full();
    test_wrap();
    test_writeback();
    test_random();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
